spike_train_decoder: RTL and testbench

- Reads the 8-bit signed membrane-voltage stream that a neuron tile drives on its output pins (integer part of v, one sample per enabled clock).
- Recovers discrete spike events using threshold plus hysteresis.
- Measures the inter-spike interval (ISI), the spike rate per fixed window, and a burst flag.
- Sits downstream of the neuron tile. It is the readout end of the neuron's voltage interface and feeds debug pins or a host-side logger.

---
 rtl/spike_train_decoder_if.sv | 24 ++
 rtl/spike_train_decoder.sv | 129 ++++++++++++
 tb/tb_spike_train_decoder.sv | 237 +++++++++++++++++++++++
 3 files changed

// File: rtl/spike_train_decoder_if.sv
// Voltage-in / spike-event-out bundle between a neuron tile readout and its decoder.
// master = tile/host side driving samples, slave = decoder producing events.
interface spike_train_decoder_if #(
   parameter int unsigned ISI_W = 16
);
   logic                    ena;
   logic signed [7:0]       v_in;
   logic                    spike;
   logic        [ISI_W-1:0] isi;
   logic                    isi_valid;
   logic        [7:0]       rate;
   logic                    rate_valid;
   logic                    burst;

   modport master (
      output ena, v_in,
      input  spike, isi, isi_valid, rate, rate_valid, burst
   );

   modport slave (
      input  ena, v_in,
      output spike, isi, isi_valid, rate, rate_valid, burst
   );
endinterface

// File: rtl/spike_train_decoder.sv
// Spike detector with hysteresis on a signed voltage stream, plus ISI, windowed
// spike rate and burst flag; all counters advance only on enabled samples.
module spike_train_decoder #(
   parameter logic signed [7:0] THRESH    = 8'sd20,
   parameter int unsigned       HYST      = 10,
   parameter int unsigned       ISI_W     = 16,
   parameter int unsigned       WIN_LOG2  = 10,
   parameter int unsigned       BURST_ISI = 8
) (
   input  logic                  clk,
   input  logic                  rst,
   spike_train_decoder_if.slave  bus
);

   localparam logic signed [8:0] REARM_LVL = $signed({THRESH[7], THRESH}) - $signed(9'(HYST));
   localparam logic [ISI_W-1:0]  ISI_MAX   = '1;
   localparam logic [ISI_W:0]    BURST_LIM = (ISI_W+1)'(BURST_ISI);

   typedef enum logic {
      ARMED,
      FIRED
   } state_t;

   state_t                r_state;
   state_t                w_state_nxt;
   logic                  w_fire;
   logic signed [8:0]     w_v_ext;

   logic                  r_have_ref;
   logic [ISI_W-1:0]      r_isi_cnt;
   logic [ISI_W:0]        w_run;
   logic [ISI_W-1:0]      w_run_sat;

   logic [WIN_LOG2-1:0]   r_win;
   logic                  w_win_last;
   logic [7:0]            r_spk_cnt;
   logic [7:0]            w_spk_nxt;

   logic                  r_spike;
   logic [ISI_W-1:0]      r_isi;
   logic                  r_isi_valid;
   logic [7:0]            r_rate;
   logic                  r_rate_valid;
   logic                  r_burst;

   assign w_v_ext = {bus.v_in[7], bus.v_in};

   always_ff @(posedge clk or posedge rst) begin
      if (rst) r_state <= ARMED;
      else     r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      w_fire      = 1'b0;
      if (bus.ena) begin
         case (r_state)
            ARMED: begin
               if (bus.v_in >= THRESH) begin
                  w_fire      = 1'b1;
                  w_state_nxt = FIRED;
               end
            end
            FIRED: begin
               if (w_v_ext < REARM_LVL) w_state_nxt = ARMED;
            end
            default: w_state_nxt = ARMED;
         endcase
      end
   end

   // Interval including the current sample; the counter itself stops at all-ones.
   assign w_run      = {1'b0, r_isi_cnt} + 1'b1;
   assign w_run_sat  = w_run[ISI_W] ? ISI_MAX : w_run[ISI_W-1:0];

   assign w_win_last = &r_win;
   assign w_spk_nxt  = (w_fire && (r_spk_cnt != 8'hFF)) ? r_spk_cnt + 8'd1 : r_spk_cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_have_ref   <= 1'b0;
         r_isi_cnt    <= '0;
         r_win        <= '0;
         r_spk_cnt    <= '0;
         r_spike      <= 1'b0;
         r_isi        <= '0;
         r_isi_valid  <= 1'b0;
         r_rate       <= '0;
         r_rate_valid <= 1'b0;
         r_burst      <= 1'b0;
      end else begin
         r_spike      <= 1'b0;
         r_isi_valid  <= 1'b0;
         r_rate_valid <= 1'b0;
         if (bus.ena) begin
            r_win <= r_win + 1'b1;
            if (w_fire) begin
               r_spike    <= 1'b1;
               r_isi_cnt  <= '0;
               r_have_ref <= 1'b1;
               // First spike after reset only establishes the reference point.
               if (r_have_ref) begin
                  r_isi       <= w_run_sat;
                  r_isi_valid <= 1'b1;
                  r_burst     <= ({1'b0, w_run_sat} <= BURST_LIM);
               end
            end else begin
               r_isi_cnt <= w_run_sat;
               if ({1'b0, w_run_sat} > BURST_LIM) r_burst <= 1'b0;
            end
            if (w_win_last) begin
               r_rate       <= w_spk_nxt;
               r_rate_valid <= 1'b1;
               r_spk_cnt    <= '0;
            end else begin
               r_spk_cnt <= w_spk_nxt;
            end
         end
      end
   end

   assign bus.spike      = r_spike;
   assign bus.isi        = r_isi;
   assign bus.isi_valid  = r_isi_valid;
   assign bus.rate       = r_rate;
   assign bus.rate_valid = r_rate_valid;
   assign bus.burst      = r_burst;

endmodule

// File: tb/tb_spike_train_decoder.sv
// Directed bench: dut_a (ISI_W=16, 16-sample window) and dut_b (ISI_W=4) share stimulus.
module tb_spike_train_decoder;

   logic              clk;
   logic              rst;
   logic              tb_ena;
   logic signed [7:0] tb_v;
   int                n_checks;
   int                n_fail;

   spike_train_decoder_if #(.ISI_W(16)) bus_a ();
   spike_train_decoder_if #(.ISI_W(4))  bus_b ();

   assign bus_a.ena  = tb_ena;
   assign bus_a.v_in = tb_v;
   assign bus_b.ena  = tb_ena;
   assign bus_b.v_in = tb_v;

   spike_train_decoder #(
      .THRESH(8'sd20), .HYST(10), .ISI_W(16), .WIN_LOG2(4), .BURST_ISI(8)
   ) dut_a (
      .clk(clk), .rst(rst), .bus(bus_a)
   );

   spike_train_decoder #(
      .THRESH(8'sd20), .HYST(10), .ISI_W(4), .WIN_LOG2(10), .BURST_ISI(8)
   ) dut_b (
      .clk(clk), .rst(rst), .bus(bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step(input logic e, input logic signed [7:0] v);
      tb_ena = e;
      tb_v   = v;
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst    = 1'b1;
      tb_ena = 1'b0;
      tb_v   = '0;
      @(posedge clk);
      #1;
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      step(1'b1, 8'sd35);
      n_checks++;
      if (bus_a.spike !== 1'b1 || bus_a.isi_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_ref_spike: spike=%0b isi_valid=%0b expected 1/0", bus_a.spike, bus_a.isi_valid);
      end
      step(1'b1, 8'sd0);
      step(1'b1, 8'sd0);
      step(1'b1, 8'sd40);
      n_checks++;
      if (bus_a.isi !== 16'd3 || bus_a.isi_valid !== 1'b1 || bus_a.burst !== 1'b1) begin
         n_fail++;
         $display("FAIL reset_pre_isi: isi=%0d valid=%0b burst=%0b expected 3/1/1", bus_a.isi, bus_a.isi_valid, bus_a.burst);
      end
      // Asynchronous assertion while FIRED with pulses and held values active
      rst = 1'b1;
      #1;
      n_checks++;
      if ({bus_a.spike, bus_a.isi_valid, bus_a.rate_valid, bus_a.burst} !== 4'b0000 ||
          bus_a.isi !== 16'd0 || bus_a.rate !== 8'd0) begin
         n_fail++;
         $display("FAIL reset_async: spike=%0b iv=%0b rv=%0b burst=%0b isi=%0d rate=%0d expected all 0",
                  bus_a.spike, bus_a.isi_valid, bus_a.rate_valid, bus_a.burst, bus_a.isi, bus_a.rate);
      end
      @(posedge clk);
      #1;
      rst = 1'b0;
      step(1'b1, 8'sd35);
      n_checks++;
      if (bus_a.spike !== 1'b1 || bus_a.isi_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_after_release: spike=%0b isi_valid=%0b expected 1/0", bus_a.spike, bus_a.isi_valid);
      end
   endtask

   task automatic test_hysteresis();
      logic signed [7:0] vec [6];
      logic              exp_spk [6];
      vec     = '{-8'sd65, 8'sd25, 8'sd15, 8'sd25, 8'sd5, 8'sd25};
      exp_spk = '{1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1};
      do_reset();
      for (int i = 0; i < 6; i++) begin
         step(1'b1, vec[i]);
         n_checks++;
         if (bus_a.spike !== exp_spk[i]) begin
            n_fail++;
            $display("FAIL hyst_spike[%0d]: got %0b expected %0b", i, bus_a.spike, exp_spk[i]);
         end
      end
      n_checks++;
      if (bus_a.isi !== 16'd4 || bus_a.isi_valid !== 1'b1 || bus_a.burst !== 1'b1) begin
         n_fail++;
         $display("FAIL hyst_isi: isi=%0d valid=%0b burst=%0b expected 4/1/1", bus_a.isi, bus_a.isi_valid, bus_a.burst);
      end
   endtask

   task automatic test_isi_burst();
      do_reset();
      step(1'b1, 8'sd50);
      for (int i = 1; i < 50; i++) step(1'b1, 8'sd0);
      step(1'b1, 8'sd50);
      n_checks++;
      if (bus_a.isi !== 16'd50 || bus_a.isi_valid !== 1'b1 || bus_a.burst !== 1'b0) begin
         n_fail++;
         $display("FAIL isi_50: isi=%0d valid=%0b burst=%0b expected 50/1/0", bus_a.isi, bus_a.isi_valid, bus_a.burst);
      end
      for (int i = 1; i < 5; i++) step(1'b1, 8'sd0);
      step(1'b1, 8'sd50);
      n_checks++;
      if (bus_a.isi !== 16'd5 || bus_a.isi_valid !== 1'b1 || bus_a.burst !== 1'b1) begin
         n_fail++;
         $display("FAIL isi_5_burst: isi=%0d valid=%0b burst=%0b expected 5/1/1", bus_a.isi, bus_a.isi_valid, bus_a.burst);
      end
      for (int j = 1; j <= 9; j++) begin
         step(1'b1, 8'sd0);
         n_checks++;
         if (bus_a.burst !== (j < 9)) begin
            n_fail++;
            $display("FAIL burst_fall[%0d]: got %0b expected %0b", j, bus_a.burst, (j < 9));
         end
      end
   endtask

   task automatic test_ena_gaps();
      do_reset();
      step(1'b1, 8'sd50);
      for (int i = 1; i <= 10; i++) begin
         for (int k = 0; k < 10; k++) begin
            step(1'b0, 8'sd50);
            n_checks++;
            if ({bus_a.spike, bus_a.isi_valid, bus_a.rate_valid} !== 3'b000) begin
               n_fail++;
               $display("FAIL gap_pulse[%0d.%0d]: spike/iv/rv=%03b expected 000", i, k,
                        {bus_a.spike, bus_a.isi_valid, bus_a.rate_valid});
            end
         end
         step(1'b1, (i == 10) ? 8'sd50 : 8'sd0);
      end
      n_checks++;
      if (bus_a.isi !== 16'd10 || bus_a.isi_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL gap_isi: isi=%0d valid=%0b expected 10/1", bus_a.isi, bus_a.isi_valid);
      end
      for (int k = 0; k < 5; k++) step(1'b0, -8'sd100);
      n_checks++;
      if (bus_a.isi !== 16'd10 || bus_a.isi_valid !== 1'b0) begin
         n_fail++;
         $display("FAIL gap_hold: isi=%0d valid=%0b expected 10/0", bus_a.isi, bus_a.isi_valid);
      end
   endtask

   task automatic test_rate();
      logic       exp_spk;
      logic       exp_rv;
      logic [7:0] exp_rate;
      do_reset();
      for (int s = 1; s <= 48; s++) begin
         exp_spk = (s == 4 || s == 10 || s == 16 || s == 24 || s == 31 || s == 33 || s == 40);
         exp_rv  = (s % 16 == 0);
         step(1'b1, exp_spk ? 8'sd50 : 8'sd0);
         n_checks++;
         if (bus_a.spike !== exp_spk || bus_a.rate_valid !== exp_rv) begin
            n_fail++;
            $display("FAIL rate_pulse[%0d]: spike=%0b rv=%0b expected %0b/%0b", s, bus_a.spike, bus_a.rate_valid, exp_spk, exp_rv);
         end
         if (exp_rv) begin
            exp_rate = (s == 16) ? 8'd3 : 8'd2;
            n_checks++;
            if (bus_a.rate !== exp_rate) begin
               n_fail++;
               $display("FAIL rate_value[%0d]: got %0d expected %0d", s, bus_a.rate, exp_rate);
            end
         end
         if (s == 20) begin
            n_checks++;
            if (bus_a.rate !== 8'd3) begin
               n_fail++;
               $display("FAIL rate_hold: got %0d expected 3", bus_a.rate);
            end
         end
      end
   endtask

   task automatic test_saturation();
      do_reset();
      step(1'b1, 8'sd50);
      for (int i = 1; i < 20; i++) step(1'b1, 8'sd0);
      step(1'b1, 8'sd50);
      n_checks++;
      if (bus_b.isi !== 4'd15 || bus_b.isi_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_20: isi=%0d valid=%0b expected 15/1", bus_b.isi, bus_b.isi_valid);
      end
      for (int i = 1; i < 14; i++) step(1'b1, 8'sd0);
      step(1'b1, 8'sd50);
      n_checks++;
      if (bus_b.isi !== 4'd14 || bus_b.isi_valid !== 1'b1) begin
         n_fail++;
         $display("FAIL sat_14: isi=%0d valid=%0b expected 14/1", bus_b.isi, bus_b.isi_valid);
      end
      for (int i = 1; i < 15; i++) step(1'b1, 8'sd0);
      step(1'b1, 8'sd50);
      n_checks++;
      if (bus_b.isi !== 4'd15 || bus_b.isi_valid !== 1'b1 || bus_b.burst !== 1'b0) begin
         n_fail++;
         $display("FAIL sat_15: isi=%0d valid=%0b burst=%0b expected 15/1/0", bus_b.isi, bus_b.isi_valid, bus_b.burst);
      end
   endtask

   initial begin
      n_checks = 0;
      n_fail   = 0;
      rst      = 1'b1;
      tb_ena   = 1'b0;
      tb_v     = '0;
      test_reset();
      test_hysteresis();
      test_isi_burst();
      test_ena_gaps();
      test_rate();
      test_saturation();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
